// File: rtl/mac_job_arbiter.sv
// Round-robin job controller sharing one MAC between two requesters: clear, stream, drain, report.
// Ack 1 cycle after request seen in IDLE; result_valid MAC_LAT cycles after last transfer; operand valid may stall freely.
module mac_job_arbiter #(
    parameter int DATA_W  = 2,
    parameter int ACC_W   = 8,
    parameter int LEN_W   = 5,
    parameter int MAC_LAT = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_valid_i,
    input  logic              req1_valid_i,
    input  logic [LEN_W-1:0]  req0_len_i,
    input  logic [LEN_W-1:0]  req1_len_i,
    output logic              req0_ack_o,
    output logic              req1_ack_o,
    input  logic [DATA_W-1:0] op0_a_i,
    input  logic [DATA_W-1:0] op0_b_i,
    input  logic [DATA_W-1:0] op1_a_i,
    input  logic [DATA_W-1:0] op1_b_i,
    input  logic              op0_valid_i,
    input  logic              op1_valid_i,
    output logic              op0_ready_o,
    output logic              op1_ready_o,
    output logic [DATA_W-1:0] mac_a_o,
    output logic [DATA_W-1:0] mac_b_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    input  logic [ACC_W-1:0]  mac_out_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_id_o,
    output logic              result_valid_o,
    output logic              busy_o
);

    localparam int LAT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               rr_q, rr_d;          // requester granted most recently
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               result_id_q, result_id_d;
    logic               result_vld_q, result_vld_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;
    logic               win;
    logic               sel_valid;
    logic               xfer;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            rr_q         <= 1'b1;
            len_q        <= '0;
            cnt_q        <= '0;
            lat_q        <= '0;
            result_q     <= '0;
            result_id_q  <= 1'b0;
            result_vld_q <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            rr_q         <= rr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            result_q     <= result_d;
            result_id_q  <= result_id_d;
            result_vld_q <= result_vld_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // On a tie the requester that did not win last time gets the grant.
    assign win       = (req0_valid_i && req1_valid_i) ? ~rr_q : req1_valid_i;
    assign sel_valid = gnt_q ? op1_valid_i : op0_valid_i;
    assign xfer      = (state_q == STREAM) && sel_valid;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        rr_d         = rr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        result_d     = result_q;
        result_id_d  = result_id_q;
        result_vld_d = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    gnt_d   = win;
                    rr_d    = win;
                    len_d   = win ? req1_len_i : req0_len_i;
                    cnt_d   = '0;
                    lat_d   = '0;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                state_d = (len_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                if (xfer) begin
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (lat_q == LAT_W'(MAC_LAT - 1)) begin
                    result_d     = mac_out_i;
                    result_id_d  = gnt_q;
                    result_vld_d = 1'b1;
                    lat_d        = '0;
                    state_d      = IDLE;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_ack_o     = ack0_q;
    assign req1_ack_o     = ack1_q;
    assign op0_ready_o    = (state_q == STREAM) && !gnt_q;
    assign op1_ready_o    = (state_q == STREAM) && gnt_q;
    assign mac_en_o       = xfer;
    assign mac_clr_o      = (state_q == CLEAR);
    assign mac_a_o        = xfer ? (gnt_q ? op1_a_i : op0_a_i) : '0;
    assign mac_b_o        = xfer ? (gnt_q ? op1_b_i : op0_b_i) : '0;
    assign result_o       = result_q;
    assign result_id_o    = result_id_q;
    assign result_valid_o = result_vld_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mac_job_arbiter.sv
// Bench for mac_job_arbiter: behavioural MAC, directed scenarios and randomized jobs
// checked against a sum-of-products / round-robin reference model.
module tb_mac_job_arbiter;

    localparam int MAC_LAT = 1;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [4:0] req0_len = '0, req1_len = '0;
    logic       req0_ack, req1_ack;
    logic [1:0] op0_a = '0, op0_b = '0, op1_a = '0, op1_b = '0;
    logic       op0_valid = 1'b0, op1_valid = 1'b0;
    logic       op0_ready, op1_ready;
    logic [1:0] mac_a, mac_b;
    logic       mac_en, mac_clr;
    logic [7:0] mac_out;
    logic [7:0] result;
    logic       result_id, result_valid, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_en = 0, n_clr = 0, n_ack0 = 0, n_ack1 = 0, n_rv = 0, n_r1 = 0, n_mux_bad = 0;
    bit last_gnt = 1'b1;
    logic [1:0] job_a [0:31];
    logic [1:0] job_b [0:31];
    bit pat [0:4];

    mac_job_arbiter #(.DATA_W(2), .ACC_W(8), .LEN_W(5), .MAC_LAT(MAC_LAT)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req0_valid_i(req0_valid), .req1_valid_i(req1_valid),
        .req0_len_i(req0_len), .req1_len_i(req1_len),
        .req0_ack_o(req0_ack), .req1_ack_o(req1_ack),
        .op0_a_i(op0_a), .op0_b_i(op0_b), .op1_a_i(op1_a), .op1_b_i(op1_b),
        .op0_valid_i(op0_valid), .op1_valid_i(op1_valid),
        .op0_ready_o(op0_ready), .op1_ready_o(op1_ready),
        .mac_a_o(mac_a), .mac_b_o(mac_b), .mac_en_o(mac_en), .mac_clr_o(mac_clr),
        .mac_out_i(mac_out),
        .result_o(result), .result_id_o(result_id), .result_valid_o(result_valid),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Behavioural MAC with a single accumulator register (MAC_LAT = 1).
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_clr) mac_out <= 8'd0;
        else if (mac_en) mac_out <= mac_out + ({6'd0, mac_a} * {6'd0, mac_b});
    end

    always @(negedge clk) begin
        if (mac_en) n_en++;
        if (mac_clr) n_clr++;
        if (req0_ack) n_ack0++;
        if (req1_ack) n_ack1++;
        if (result_valid) n_rv++;
        if (op1_ready) n_r1++;
        if (!mac_en && (mac_a != 2'd0 || mac_b != 2'd0)) n_mux_bad++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int expected_sum(input int len);
        int s = 0;
        for (int i = 0; i < len; i++) s += int'(job_a[i]) * int'(job_b[i]);
        return s % 256;
    endfunction

    // Drives one job for requester id; mode 0 = valid always, 1 = pat[] on ready cycles, 2 = random stalls.
    task automatic do_job(input bit id, input int len, input int mode, input bit pre_raised,
                          output logic [7:0] res, output bit rid, output int lat_ack,
                          output int lat_res, output bit to);
        int idx = 0, pidx = 0, t_last = 0, start;
        bit acked = 0, got = 0, v, rdy;
        to = 0; res = '0; rid = 0; lat_ack = -1; lat_res = -1;
        if (!pre_raised) begin
            if (id) begin req1_valid = 1; req1_len = 5'(len); end
            else    begin req0_valid = 1; req0_len = 5'(len); end
        end
        start = cyc;
        for (int i = 0; i < 200 && !acked; i++) begin
            tick();
            if (id ? req1_ack : req0_ack) begin acked = 1; lat_ack = cyc - start; end
        end
        if (id) req1_valid = 0; else req0_valid = 0;
        for (int i = 0; i < 400 && acked && !got; i++) begin
            tick();
            if (result_valid) begin
                got = 1; res = result; rid = result_id; lat_res = cyc - t_last;
            end else if (idx < len) begin
                v = (mode == 0) ? 1'b1 : (mode == 1) ? ((pidx < 5) ? pat[pidx] : 1'b1)
                                                     : ($urandom_range(0, 2) != 0);
                rdy = id ? op1_ready : op0_ready;
                if (id) begin op1_valid = v; op1_a = job_a[idx]; op1_b = job_b[idx]; end
                else    begin op0_valid = v; op0_a = job_a[idx]; op0_b = job_b[idx]; end
                if (rdy) pidx++;
                if (v && rdy) begin idx++; t_last = cyc + 1; end
            end else begin
                if (id) op1_valid = 0; else op0_valid = 0;
            end
        end
        op0_valid = 0; op1_valid = 0;
        if (!acked || !got) to = 1;
    endtask

    task automatic do_reset();
        reset_i = 0;
        tick(); tick();
        reset_i = 1;
        last_gnt = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        #2;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (result !== 8'd0 || result_id !== 1'b0) begin bad++; $display("FAIL reset_result: got %0d/%b want 0/0", result, result_id); end
        total++; if ({req0_ack, req1_ack, result_valid, mac_clr, mac_en, op0_ready, op1_ready} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000000", {req0_ack, req1_ack, result_valid, mac_clr, mac_en, op0_ready, op1_ready}); end
        tick(); tick();
        reset_i = 1;
        tick();
        total++; if (busy !== 1'b0 || mac_clr !== 1'b0) begin bad++; $display("FAIL post_reset_idle: busy=%b clr=%b want 0 0", busy, mac_clr); end
    endtask

    task automatic test_basic();
        logic [7:0] r; bit id, to; int la, lr, e0, c0, m0;
        job_a[0] = 1; job_b[0] = 1; job_a[1] = 2; job_b[1] = 2;
        e0 = n_en; c0 = n_clr; m0 = n_ack0;
        do_job(0, 2, 0, 0, r, id, la, lr, to);
        last_gnt = 0;
        total++; if (to) begin bad++; $display("FAIL basic_timeout: got timeout want completion"); end
        total++; if (la !== 1) begin bad++; $display("FAIL basic_ack_latency: got %0d want 1", la); end
        total++; if (r !== 8'd5 || id !== 1'b0) begin bad++; $display("FAIL basic_result: got %0d/%b want 5/0", r, id); end
        total++; if (lr !== MAC_LAT) begin bad++; $display("FAIL basic_result_latency: got %0d want %0d", lr, MAC_LAT); end
        total++; if (n_en - e0 !== 2 || n_clr - c0 !== 1 || n_ack0 - m0 !== 1) begin
            bad++; $display("FAIL basic_pulses: en=%0d clr=%0d ack=%0d want 2 1 1", n_en - e0, n_clr - c0, n_ack0 - m0); end
        tick();
        total++; if (result_valid !== 1'b0 || result !== 8'd5 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_hold: rv=%b result=%0d busy=%b want 0 5 0", result_valid, result, busy); end
    endtask

    task automatic test_tie();
        logic [7:0] r; bit id, to, exp_w; int la, lr, a0, a1;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            exp_w = ~last_gnt;
            req0_len = 1; req1_len = 1; req0_valid = 1; req1_valid = 1;
            a0 = n_ack0; a1 = n_ack1;
            job_a[0] = exp_w ? 2'd3 : 2'd1; job_b[0] = exp_w ? 2'd3 : 2'd2;
            do_job(exp_w, 1, 0, 1, r, id, la, lr, to);
            last_gnt = exp_w;
            total++; if (to || id !== exp_w || r !== 8'(expected_sum(1))) begin
                bad++; $display("FAIL tie_first_round%0d: to=%b id=%b res=%0d want id %b res %0d", round, to, id, r, exp_w, expected_sum(1)); end
            total++; if ((exp_w ? n_ack0 - a0 : n_ack1 - a1) !== 0) begin
                bad++; $display("FAIL tie_loser_acked_round%0d: got extra ack want none", round); end
            job_a[0] = exp_w ? 2'd1 : 2'd3; job_b[0] = exp_w ? 2'd2 : 2'd3;
            do_job(~exp_w, 1, 0, 1, r, id, la, lr, to);
            last_gnt = ~exp_w;
            total++; if (to || id !== ~exp_w || r !== 8'(expected_sum(1))) begin
                bad++; $display("FAIL tie_second_round%0d: to=%b id=%b res=%0d want id %b res %0d", round, to, id, r, ~exp_w, expected_sum(1)); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] r; bit id, to; int la, lr, e0, r1, mb;
        job_a[0] = 1; job_b[0] = 2; job_a[1] = 3; job_b[1] = 1; job_a[2] = 2; job_b[2] = 2;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1;
        e0 = n_en; r1 = n_r1; mb = n_mux_bad;
        do_job(0, 3, 1, 0, r, id, la, lr, to);
        last_gnt = 0;
        total++; if (to || r !== 8'd9 || id !== 1'b0) begin bad++; $display("FAIL bp_result: to=%b got %0d/%b want 9/0", to, r, id); end
        total++; if (n_en - e0 !== 3) begin bad++; $display("FAIL bp_mac_en_count: got %0d want 3", n_en - e0); end
        total++; if (n_r1 - r1 !== 0) begin bad++; $display("FAIL bp_other_ready: got %0d cycles want 0", n_r1 - r1); end
        total++; if (n_mux_bad - mb !== 0) begin bad++; $display("FAIL bp_operand_gating: got %0d cycles want 0", n_mux_bad - mb); end
    endtask

    task automatic test_zero_len();
        logic [7:0] r; bit id, to; int la, lr, e0, c0;
        e0 = n_en; c0 = n_clr;
        do_job(1, 0, 0, 0, r, id, la, lr, to);
        last_gnt = 1;
        total++; if (to || r !== 8'd0 || id !== 1'b1) begin bad++; $display("FAIL zero_result: to=%b got %0d/%b want 0/1", to, r, id); end
        total++; if (n_en - e0 !== 0 || n_clr - c0 !== 1) begin bad++; $display("FAIL zero_pulses: en=%0d clr=%0d want 0 1", n_en - e0, n_clr - c0); end
    endtask

    task automatic test_wrap();
        logic [7:0] r; bit id, to; int la, lr;
        for (int i = 0; i < 30; i++) begin job_a[i] = 3; job_b[i] = 3; end
        do_job(0, 30, 0, 0, r, id, la, lr, to);
        last_gnt = 0;
        total++; if (to || r !== 8'd14) begin bad++; $display("FAIL wrap_result: to=%b got %0d want 14", to, r); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r; bit id, to; int la, lr, sent = 0, rv0;
        op0_valid = 0; req0_len = 4; req0_valid = 1;
        for (int i = 0; i < 50 && sent < 2; i++) begin
            tick();
            if (req0_ack) req0_valid = 0;
            if (op0_ready) begin op0_valid = 1; op0_a = 1; op0_b = 1; sent++; end
        end
        tick();
        total++; if (sent !== 2 || busy !== 1'b1) begin bad++; $display("FAIL midreset_setup: sent=%0d busy=%b want 2 1", sent, busy); end
        rv0 = n_rv;
        reset_i = 0;
        #1;
        total++; if ({busy, op0_ready, mac_en, result_valid} !== 4'd0 || result !== 8'd0) begin
            bad++; $display("FAIL midreset_outputs: bsy/rdy/en/rv=%b result=%0d want 0000 0", {busy, op0_ready, mac_en, result_valid}, result); end
        tick(); tick();
        op0_valid = 0; reset_i = 1; last_gnt = 1;
        tick(); tick(); tick();
        total++; if (n_rv - rv0 !== 0) begin bad++; $display("FAIL midreset_no_result: got %0d pulses want 0", n_rv - rv0); end
        job_a[0] = 1; job_b[0] = 1;
        do_job(0, 1, 0, 0, r, id, la, lr, to);
        last_gnt = 0;
        total++; if (to || r !== 8'd1 || id !== 1'b0) begin bad++; $display("FAIL midreset_next_job: to=%b got %0d/%b want 1/0", to, r, id); end
    endtask

    task automatic test_random();
        logic [7:0] r; bit id, to, rq; int la, lr, len, e0, c0, exp;
        for (int j = 0; j < 20; j++) begin
            rq = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) begin job_a[i] = 2'($urandom); job_b[i] = 2'($urandom); end
            exp = expected_sum(len);
            e0 = n_en; c0 = n_clr;
            do_job(rq, len, 2, 0, r, id, la, lr, to);
            last_gnt = rq;
            total++; if (to || r !== 8'(exp) || id !== rq) begin
                bad++; $display("FAIL rand_job%0d: to=%b got %0d/%b want %0d/%b", j, to, r, id, exp, rq); end
            total++; if (n_en - e0 !== len || n_clr - c0 !== 1) begin
                bad++; $display("FAIL rand_pulses%0d: en=%0d clr=%0d want %0d 1", j, n_en - e0, n_clr - c0, len); end
            if (len > 0) begin
                total++; if (lr !== MAC_LAT) begin bad++; $display("FAIL rand_latency%0d: got %0d want %0d", j, lr, MAC_LAT); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_backpressure();
        test_zero_len();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_job_arbiter.md
Name: mac_job_arbiter

Overview:
- Controller that shares one MAC unit (2-bit operands, 8-bit accumulator) between two requesters.
- Each requester submits a dot-product job (length + operand stream). The block arbitrates round-robin, clears the MAC, streams the granted requester's operand pairs into it, waits for the pipeline to drain, then returns the accumulated result tagged with the requester id.
- Sits between the operand sources and the MAC datapath. It replaces the manual enable/reset sequencing a bench otherwise does by hand.

Parameters:
- DATA_W, 2: operand width (a, b).
- ACC_W, 8: accumulator/result width.
- LEN_W, 5: job length field width; max job length is 2^LEN_W-1 pairs.
- MAC_LAT, 1: cycles from the last mac_en edge until mac_out holds the final sum (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  job request; req_len must be stable while valid.
- req0_len / req1_len  in  LEN_W  number of operand pairs in the job.
- req0_ack / req1_ack  out  1  one-cycle pulse: job accepted and granted.
- op0_a, op0_b / op1_a, op1_b  in  DATA_W  operand pair.
- op0_valid / op1_valid  in  1  operand pair valid.
- op0_ready / op1_ready  out  1  controller accepts the pair; transfer = valid & ready.
- mac_a, mac_b  out  DATA_W  operands to the MAC.
- mac_en  out  1  MAC accumulate enable.
- mac_clr  out  1  MAC accumulator clear.
- mac_out  in  ACC_W  MAC accumulator value.
- result  out  ACC_W  last completed job result.
- result_id  out  1  requester that owns result.
- result_valid  out  1  one-cycle pulse when result/result_id update.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all outputs 0, including result and result_id.
  - Length and transfer counters 0.
  - Round-robin pointer set so requester 0 wins the first tie.
- State IDLE:
  - req_valid is sampled only in IDLE.
  - If either is high, grant at the next edge and go to CLEAR.
  - Tie: grant the requester not granted most recently.
  - Requests raised while busy wait; they are not queued beyond the level-held valid.
- State CLEAR (1 cycle):
  - Registered reqN_ack=1 for the granted requester only.
  - mac_clr=1; latch req_len and the grant id; update the round-robin pointer.
  - Next state: STREAM if len>0, else DRAIN.
- State STREAM:
  - opN_ready=1 for the granted requester only; the other requester's ready stays 0.
  - mac_en = opN_valid & opN_ready (combinational); mac_a/mac_b mux the granted requester's operands. mac_a/mac_b are 0 when mac_en=0.
  - Each transfer increments the count. On the edge of transfer number len, go to DRAIN; ready drops the cycle after.
  - Valid may stall arbitrarily with no penalty.
- State DRAIN:
  - Waits MAC_LAT edges after entry.
  - On the final edge: result<=mac_out, result_id<=grant, result_valid<=1 for one cycle; go to IDLE.
- Latency:
  - Request to ack: ack visible the cycle after valid is seen in IDLE.
  - Last transfer to result_valid: asserted MAC_LAT cycles after the last transfer edge.
- A requester must drop req_valid after ack. If it is still high in IDLE, it is treated as a new job.
- Arithmetic:
  - The controller does no math. result equals the MAC's sum modulo 2^ACC_W; wrap is passed through, no saturation.
  - len=0 produces result 0, since the MAC was cleared.
- Reset mid-job:
  - Immediate return to IDLE; outputs 0; the in-flight job is dropped with no result_valid.
  - mac_clr is not driven during reset; the next job's CLEAR scrubs the MAC.
- result holds its value between jobs.
- busy=0 only in IDLE.

Test Plan:
- Basic job, MAC_LAT=1: after reset, req0 len=2, pairs (1,1),(2,2) → req0_ack 1 cycle; mac_clr 1 cycle; 2 mac_en pulses; result=5, result_id=0, result_valid one pulse 1 cycle after the last transfer.
- Tie: req0 and req1 valid in the same IDLE cycle after reset → req0 granted first. req1's job (len=1, (3,3)) then runs → result=9, id=1. A second tie → req1's previous win means req0 is granted.
- Back-pressure: op0_valid toggles 1,0,0,1,1 over len=3 with pairs (1,2),(3,1),(2,2) → exactly 3 mac_en pulses; result=9; op1_ready stays 0 throughout.
- Zero length: req1 len=0 → ack, CLEAR, DRAIN, then result=0, id=1; no mac_en pulses.
- Wrap: len=30, all pairs (3,3) → result=270 mod 256=14.
- Reset mid-STREAM: reset asserted after 2 of 4 transfers → busy, ready, mac_en, result and result_valid all 0 immediately. The next job of len=1, (1,1) returns 1.
